// File: rtl/mp_mgmt_csr.sv
// Management-bus CSR responder: core config registers, external IRQ controller, EPC/cause capture.
// Optional perf counters PERF0..7 are built when MP_MGMT_PERF_EN is defined.
module mp_mgmt_csr #(
  parameter logic [31:0] BASE = 32'h0000_0000,
  parameter int unsigned NIRQ = 8
) (
  input  logic            clk,
  input  logic            sys_rst,
  input  logic            mgmt_req,
  input  logic            mgmt_rwn,
  input  logic [31:0]     mgmt_adr,
  input  logic [1:0]      mgmt_wen,
  input  logic [31:0]     mgmt_txd,
  output logic            mgmt_ack,
  output logic            mgmt_rxe,
  output logic [31:0]     mgmt_rxd,
  output logic            m32,
  output logic            mie,
  output logic [31:0]     mvec,
  output logic [31:0]     mepc,
  input  logic            mie_set,
  input  logic            swi,
  input  logic [31:0]     pc_epc,
  output logic            exi,
  output logic [4:0]      exi_code,
  input  logic [NIRQ-1:0] irq_in,
  input  logic [7:0]      perf
);

  typedef enum logic [1:0] {StIdle, StAck, StRdata, StHold} state_e;

  state_e         state_q;
  logic           rd_q;
  logic           ack_q, rxe_q;
  logic [31:0]    rxd_q, rbuf_q;
  logic           m32_q, mie_q, mie_d;
  logic [31:0]    mvec_q, mepc_q, mepc_d;
  logic           cause_swi_q, cause_swi_d;
  logic [4:0]     cause_code_q, cause_code_d;
  logic [NIRQ-1:0] pend_q, pend_d, mask_q, mask_d, irq_q, pend_masked;
  logic [4:0]     code;
  logic [31:0]    rdata, perf_rd;
  logic           hit, accept, wr;
  logic [5:0]     word;
  logic           wr_ctrl, wr_mvec, wr_mepc, wr_pend, wr_mask;
  logic           hw_entry;
  logic           unused_bits;

  function automatic logic [31:0] merge(input logic [31:0] old_v, input logic [31:0] new_v,
                                        input logic [1:0] wen);
    merge = {wen[1] ? new_v[31:16] : old_v[31:16], wen[0] ? new_v[15:0] : old_v[15:0]};
  endfunction

  assign hit     = (mgmt_adr[31:8] == BASE[31:8]);
  assign word    = mgmt_adr[7:2];
  assign accept  = (state_q == StIdle) && mgmt_req;
  assign wr      = accept && !mgmt_rwn && hit;
  assign wr_ctrl = wr && (word == 6'h00);
  assign wr_mvec = wr && (word == 6'h01);
  assign wr_mepc = wr && (word == 6'h02);
  assign wr_pend = wr && (word == 6'h04);
  assign wr_mask = wr && (word == 6'h05);

  // Interrupt request and lowest-index priority encode
  assign pend_masked = pend_q & mask_q;
  assign exi         = mie_q && (|pend_masked);
  assign exi_code    = code;
  assign hw_entry    = swi || exi;

  always_comb begin
    code = '0;
    for (int i = NIRQ - 1; i >= 0; i--) begin
      if (pend_masked[i]) code = 5'(i);
    end
  end

  always_comb begin
    // W1C first, then rising edges so a same-cycle edge keeps the bit set
    pend_d = pend_q;
    mask_d = mask_q;
    for (int i = 0; i < NIRQ; i++) begin
      if (wr_pend && mgmt_txd[i] && mgmt_wen[i/16]) pend_d[i] = 1'b0;
      if (wr_mask && mgmt_wen[i/16]) mask_d[i] = mgmt_txd[i];
    end
    pend_d = pend_d | (irq_in & ~irq_q);
  end

  always_comb begin
    mie_d = mie_q;
    if (wr_ctrl && mgmt_wen[0]) mie_d = mgmt_txd[1];
    if (mie_set) mie_d = 1'b1;
    if (hw_entry) mie_d = 1'b0;

    mepc_d = wr_mepc ? merge(mepc_q, mgmt_txd, mgmt_wen) : mepc_q;
    if (hw_entry) mepc_d = pc_epc;

    cause_swi_d  = cause_swi_q;
    cause_code_d = cause_code_q;
    if (swi) begin
      cause_swi_d  = 1'b1;
      cause_code_d = 5'd31;
    end else if (exi) begin
      cause_swi_d  = 1'b0;
      cause_code_d = code;
    end
  end

  always_ff @(posedge clk or posedge sys_rst) begin
    if (sys_rst) begin
      m32_q        <= 1'b0;
      mie_q        <= 1'b0;
      mvec_q       <= '0;
      mepc_q       <= '0;
      cause_swi_q  <= 1'b0;
      cause_code_q <= '0;
      pend_q       <= '0;
      mask_q       <= '0;
      irq_q        <= '0;
    end else begin
      if (wr_ctrl && mgmt_wen[0]) m32_q <= mgmt_txd[0];
      if (wr_mvec) mvec_q <= merge(mvec_q, mgmt_txd, mgmt_wen);
      mie_q        <= mie_d;
      mepc_q       <= mepc_d;
      cause_swi_q  <= cause_swi_d;
      cause_code_q <= cause_code_d;
      pend_q       <= pend_d;
      mask_q       <= mask_d;
      irq_q        <= irq_in;
    end
  end

`ifdef MP_MGMT_PERF_EN
  logic [31:0] cnt_q [8];
  logic        wr_perf;

  assign wr_perf = wr && (word[5:3] == 3'b001);
  assign perf_rd = cnt_q[word[2:0]];

  always_ff @(posedge clk or posedge sys_rst) begin
    if (sys_rst) begin
      for (int i = 0; i < 8; i++) cnt_q[i] <= '0;
    end else begin
      for (int i = 0; i < 8; i++) begin
        if (wr_perf && (word[2:0] == 3'(i))) begin
          cnt_q[i] <= merge(cnt_q[i], mgmt_txd, mgmt_wen);
        end else if (perf[i]) begin
          cnt_q[i] <= cnt_q[i] + 32'd1;
        end
      end
    end
  end

  assign unused_bits = ^mgmt_adr[1:0];
`else
  assign perf_rd     = '0;
  assign unused_bits = ^{mgmt_adr[1:0], perf};
`endif

  always_comb begin
    rdata = '0;
    case (word)
      6'h00:   rdata = {30'd0, mie_q, m32_q};
      6'h01:   rdata = mvec_q;
      6'h02:   rdata = mepc_q;
      6'h03:   rdata = {23'd0, cause_swi_q, 3'd0, cause_code_q};
      6'h04:   rdata = 32'(pend_q);
      6'h05:   rdata = 32'(mask_q);
      default: rdata = '0;
    endcase
    if (word[5:3] == 3'b001) rdata = perf_rd;
    if (!hit) rdata = '0;
  end

  // Read data is snapshotted at accept, so same-cycle hardware updates are not seen
  always_ff @(posedge clk or posedge sys_rst) begin
    if (sys_rst) begin
      state_q <= StIdle;
      rd_q    <= 1'b0;
      rbuf_q  <= '0;
      ack_q   <= 1'b0;
      rxe_q   <= 1'b0;
      rxd_q   <= '0;
    end else begin
      case (state_q)
        StIdle: begin
          if (accept) begin
            rd_q    <= mgmt_rwn;
            rbuf_q  <= rdata;
            ack_q   <= 1'b1;
            state_q <= StAck;
          end
        end
        StAck: begin
          ack_q <= 1'b0;
          if (rd_q) begin
            rxe_q   <= 1'b1;
            rxd_q   <= rbuf_q;
            state_q <= StRdata;
          end else begin
            state_q <= StHold;
          end
        end
        StRdata: begin
          rxe_q   <= 1'b0;
          rxd_q   <= '0;
          state_q <= StHold;
        end
        StHold: begin
          if (!mgmt_req) state_q <= StIdle;
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  assign mgmt_ack = ack_q;
  assign mgmt_rxe = rxe_q;
  assign mgmt_rxd = rxd_q;
  assign m32      = m32_q;
  assign mie      = mie_q;
  assign mvec     = mvec_q;
  assign mepc     = mepc_q;

endmodule

// File: tb/tb_mp_mgmt_csr.sv
// Scoreboard bench for mp_mgmt_csr: expected read data is queued at issue, a monitor checks rxd.
module tb_mp_mgmt_csr;

  logic        clk = 1'b0;
  logic        sys_rst = 1'b1;
  logic        mgmt_req = 1'b0, mgmt_rwn = 1'b1;
  logic [31:0] mgmt_adr = '0, mgmt_txd = '0;
  logic [1:0]  mgmt_wen = '0;
  logic        mgmt_ack, mgmt_rxe;
  logic [31:0] mgmt_rxd;
  logic        m32, mie, exi;
  logic [31:0] mvec, mepc;
  logic        mie_set = 1'b0, swi = 1'b0;
  logic [31:0] pc_epc = '0;
  logic [4:0]  exi_code;
  logic [7:0]  irq_in = '0, perf = '0;

  int          n_chk = 0, n_fail = 0;
  logic [31:0] exp_q[$];
  logic        ack_exi;
  logic [4:0]  ack_code;
  logic [31:0] perf_exp;

  mp_mgmt_csr #(.BASE(32'h0000_0000), .NIRQ(8)) dut (
    .clk(clk), .sys_rst(sys_rst),
    .mgmt_req(mgmt_req), .mgmt_rwn(mgmt_rwn), .mgmt_adr(mgmt_adr), .mgmt_wen(mgmt_wen),
    .mgmt_txd(mgmt_txd), .mgmt_ack(mgmt_ack), .mgmt_rxe(mgmt_rxe), .mgmt_rxd(mgmt_rxd),
    .m32(m32), .mie(mie), .mvec(mvec), .mepc(mepc),
    .mie_set(mie_set), .swi(swi), .pc_epc(pc_epc),
    .exi(exi), .exi_code(exi_code), .irq_in(irq_in), .perf(perf)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  // Monitor: every read-data pulse must match the oldest queued expectation
  initial begin
    forever begin
      @(negedge clk);
      if (mgmt_rxe === 1'b1) begin
        if (exp_q.size() == 0) check("unexpected rxe", 32'(mgmt_rxe), 32'd0);
        else check("rxd", mgmt_rxd, exp_q.pop_front());
      end
    end
  end

  task automatic xact(input logic rd, input logic [31:0] adr, input logic [1:0] wen,
                      input logic [31:0] d, input logic [31:0] exp, input int hold,
                      input logic [7:0] irqv, input string name);
    int cyc;
    int extra;
    @(posedge clk); #1;
    if (rd) exp_q.push_back(exp);
    mgmt_req = 1'b1; mgmt_rwn = rd; mgmt_adr = adr; mgmt_wen = wen; mgmt_txd = d;
    irq_in = irqv;
    cyc = 0;
    do begin
      @(posedge clk); #1;
      cyc++;
    end while (!mgmt_ack && cyc < 8);
    check({name, " ack latency"}, 32'(cyc), 32'd1);
    ack_exi  = exi;
    ack_code = exi_code;
    @(posedge clk); #1;
    check({name, " ack single"}, 32'(mgmt_ack), 32'd0);
    check({name, " rxe at N+2"}, 32'(mgmt_rxe), 32'(rd));
    if (rd) begin
      @(posedge clk); #1;
      check({name, " rxe clear"}, 32'(mgmt_rxe), 32'd0);
      check({name, " rxd clear"}, mgmt_rxd, 32'd0);
    end
    extra = 0;
    repeat (hold) begin
      @(posedge clk); #1;
      if (mgmt_ack) extra++;
    end
    if (hold > 0) check({name, " no re-ack while held"}, 32'(extra), 32'd0);
    mgmt_req = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic wr(input logic [31:0] adr, input logic [1:0] wen, input logic [31:0] d);
    xact(1'b0, adr, wen, d, 32'd0, 0, 8'h00, "wr");
  endtask

  task automatic rd(input logic [31:0] adr, input logic [31:0] exp);
    xact(1'b1, adr, 2'b00, 32'd0, exp, 0, 8'h00, "rd");
  endtask

  task automatic pulse_irq(input logic [7:0] v);
    @(posedge clk); #1; irq_in = v;
    @(posedge clk); #1; irq_in = '0;
  endtask

  initial begin
    repeat (3) @(posedge clk);
    #1;
    check("rst ack", 32'(mgmt_ack), 32'd0);
    check("rst rxe", 32'(mgmt_rxe), 32'd0);
    check("rst rxd", mgmt_rxd, 32'd0);
    check("rst m32/mie", {30'd0, mie, m32}, 32'd0);
    check("rst mvec", mvec, 32'd0);
    check("rst mepc", mepc, 32'd0);
    check("rst exi", {27'd0, exi_code}, 32'(exi));
    sys_rst = 1'b0;
    rd(32'h0C, 32'h0);

    // Halfword merges
    wr(32'h04, 2'b11, 32'hDEAD_BEEF);
    check("mvec full", mvec, 32'hDEAD_BEEF);
    wr(32'h04, 2'b01, 32'h0000_1234);
    check("mvec low half", mvec, 32'hDEAD_1234);
    rd(32'h04, 32'hDEAD_1234);
    wr(32'h04, 2'b00, 32'hFFFF_FFFF);
    rd(32'h04, 32'hDEAD_1234);
    wr(32'h00, 2'b01, 32'h1);
    check("m32 set", {30'd0, mie, m32}, 32'h1);

    // Interrupt take
    wr(32'h14, 2'b01, 32'h0C);
    pulse_irq(8'h08);
    pulse_irq(8'h04);
    rd(32'h10, 32'h0C);
    check("exi off while mie=0", 32'(exi), 32'd0);
    pc_epc = 32'h100;
    wr(32'h00, 2'b01, 32'h3);
    check("exi when mie set", 32'(ack_exi), 32'd1);
    check("exi_code lowest", 32'(ack_code), 32'd2);
    check("mie cleared by take", {30'd0, mie, m32}, 32'h1);
    check("mepc on take", mepc, 32'h100);
    rd(32'h08, 32'h100);
    rd(32'h0C, 32'h002);

    // W1C vs same-cycle edge on bit 1
    pulse_irq(8'h02);
    xact(1'b0, 32'h10, 2'b01, 32'h06, 32'd0, 0, 8'h02, "w1c race");
    rd(32'h10, 32'h0A);
    wr(32'h10, 2'b10, 32'hFF);
    rd(32'h10, 32'h0A);
    wr(32'h10, 2'b01, 32'hFF);
    rd(32'h10, 32'h00);

    // mie_set, then swi racing mie_set
    @(posedge clk); #1; mie_set = 1'b1;
    @(posedge clk); #1; mie_set = 1'b0;
    check("mie_set", 32'(mie), 32'd1);
    pc_epc = 32'h40;
    @(posedge clk); #1; swi = 1'b1; mie_set = 1'b1;
    @(posedge clk); #1; swi = 1'b0; mie_set = 1'b0;
    check("swi beats mie_set", 32'(mie), 32'd0);
    check("mepc on swi", mepc, 32'h40);
    rd(32'h0C, 32'h11F);

    // Out of window and unmapped
    xact(1'b1, 32'h0000_1004, 2'b00, 32'd0, 32'd0, 4, 8'h00, "oow rd held");
    wr(32'h0000_1004, 2'b11, 32'h5555_5555);
    check("oow write dropped", mvec, 32'hDEAD_1234);
    rd(32'h18, 32'h0);

    // Perf counter wrap
    wr(32'h20, 2'b11, 32'hFFFF_FFFE);
    @(posedge clk); #1; perf = 8'h01;
    repeat (3) @(posedge clk);
    #1; perf = 8'h00;
`ifdef MP_MGMT_PERF_EN
    perf_exp = 32'h1;
`else
    perf_exp = 32'h0;
`endif
    rd(32'h20, perf_exp);
    rd(32'h24, 32'h0);

    // Reset during ACK of a read
    @(posedge clk); #1;
    mgmt_req = 1'b1; mgmt_rwn = 1'b1; mgmt_adr = 32'h04;
    @(posedge clk); #1;
    check("ack before abort", 32'(mgmt_ack), 32'd1);
    sys_rst = 1'b1;
    #1;
    check("ack async low", 32'(mgmt_ack), 32'd0);
    check("mvec reset", mvec, 32'd0);
    check("mepc reset", mepc, 32'd0);
    mgmt_req = 1'b0;
    @(posedge clk); #1;
    sys_rst = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    rd(32'h0C, 32'h0);
    rd(32'h04, 32'h0);
    wr(32'h04, 2'b11, 32'h1234_5678);
    rd(32'h04, 32'h1234_5678);

    repeat (3) @(posedge clk);
    #1;
    check("scoreboard drained", 32'(exp_q.size()), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/mp_mgmt_csr.md
# mp_mgmt_csr

Management-bus responder that sits on the far end of the core's `mgmt_*` port. It hosts the core's configuration registers (`m32`, `mvec`, `mepc`, `mie`) and a small external-interrupt controller that drives `exi`/`exi_code`. It latches the exception PC and cause on interrupt or software-call entry. Optionally it carries eight performance counters fed by the core's `perf` line.

## Interface
- `BASE`, default 32'h0000_0000: window base. Hit when `mgmt_adr[31:8] == BASE[31:8]`.
- `NIRQ`, default 8: external IRQ lines, 1..31. Code 31 is reserved for swi.
- `clk`  in  1  clock
- `sys_rst`  in  1  reset, asynchronous, active-high
- `mgmt_req`  in  1  request, held with `adr`/`rwn`/`wen`/`txd` stable until `ack`
- `mgmt_rwn`  in  1  1 = read, 0 = write
- `mgmt_adr`  in  32  byte address; `[7:2]` selects the word
- `mgmt_wen`  in  2  write enables: `[0]` covers bits 15:0, `[1]` covers bits 31:16
- `mgmt_txd`  in  32  write data
- `mgmt_ack`  out  1  one-cycle accept pulse
- `mgmt_rxe`  out  1  one-cycle read-data-valid pulse
- `mgmt_rxd`  out  32  read data, valid while `rxe` is high
- `m32`, `mie`  out  1 each  config bits
- `mvec`, `mepc`  out  32 each  vector and exception PC
- `mie_set`  in  1  WFI/MRET from core: set `mie`
- `swi`  in  1  ECALL issue pulse
- `pc_epc`  in  32  PC to save on entry
- `exi`  out  1  interrupt request, combinational
- `exi_code`  out  5  lowest enabled pending index
- `irq_in`  in  NIRQ  level IRQ inputs, synchronous to `clk`
- `perf`  in  8  performance event strobes

## Operation
- Register map, keyed by `adr[7:0]`:
  - 0x00 CTRL: `[0]` m32, `[1]` mie.
  - 0x04 MVEC.
  - 0x08 MEPC.
  - 0x0C CAUSE, read-only: `[4:0]` code, `[8]` swi.
  - 0x10 PEND: a read returns pending; a write-1 clears the bit.
  - 0x14 MASK, read/write.
  - 0x20–0x3C PERF0..7.
  - Unmapped offsets and out-of-window accesses: reads return 0, writes are dropped. All accesses are always acked; the bus never hangs.
- Writes are byte-lane-free halfword merges under `wen`. `wen = 00` still acks and changes nothing.
- Pending: bit i sets on a rising edge of `irq_in[i]` (previous-sample register). It clears only by W1C.
- `exi = mie & |(pend & mask)`. `exi_code` is the lowest set index of `pend & mask`, zero-extended.
- Take (clock edge with `exi` = 1): `mie <= 0`, `mepc <= pc_epc`, `cause <= {swi = 0, exi_code}`.
- `swi` pulse: `mie <= 0`, `mepc <= pc_epc`, `cause <= {1, 5'd31}`. Priority: swi over take.
- `mie_set`: `mie <= 1`, unless a take or swi occurs in the same cycle (take/swi wins).
- FSM states:
  - IDLE: on `req`, latch the command, perform the write or capture the read → ACK.
  - ACK: `ack` = 1 → RDATA if read, else HOLD.
  - RDATA: `rxe` = 1 → HOLD.
  - HOLD: wait for `req` = 0 → IDLE.

## Timing
- `req` sampled high at edge N. `ack` is high in cycle N+1. A write is visible on the outputs from N+1. For a read, `rxe`/`rxd` are high in N+2, and `rxd` returns to 0 after that.
- Read data is captured at edge N. A hardware update in the same cycle is therefore not reflected.
- Minimum spacing between accepts: `req` must be seen low for one cycle after the ack/rxe pulse.
- Same-cycle conflicts:
  - Hardware take/swi beats a mgmt write to CTRL.mie, MEPC or CAUSE. Other CTRL bits written in that cycle still land.
  - An `irq` edge beats a W1C on the same bit; the bit stays set.
  - A PERF write beats that counter's increment.
- Reset values: all outputs 0 (`ack`, `rxe`, `rxd`, `m32`, `mie`, `mvec`, `mepc`, `exi`, `exi_code`); pend, mask, cause, counters and previous-IRQ samples all 0; FSM = IDLE.
- Reset asserted mid-transaction aborts immediately: `ack`/`rxe` go low asynchronously, and there is no completion after release.

## Configuration
- `MP_MGMT_PERF_EN` defined: PERF0..7 are 32-bit counters. PERFi increments on each clock with `perf[i]` = 1, wraps 0xFFFF_FFFF→0, and is writable under `wen`.
- `MP_MGMT_PERF_EN` undefined: no counters. 0x20–0x3C behave as unmapped (read 0, writes dropped) and `perf` is ignored.

## Test plan
- Write 0x04 = 0xDEAD_BEEF, `wen = 11`, then write `wen = 01` data 0x0000_1234 → read 0x04 gives 0xDEAD_1234; `ack` at N+1, `rxe` at N+2.
- MASK = 0x0C, CTRL = 0x2, pulse `irq_in[3]` then `irq_in[2]` → `exi` = 1, `exi_code` = 2; take edge with `pc_epc` = 0x100 → `mie` = 0, MEPC = 0x100, CAUSE = 0x002.
- `swi` pulse and `mie_set` in the same cycle, `pc_epc` = 0x40 → `mie` = 0, CAUSE = 0x11F, MEPC = 0x40.
- Read 0x0000_1004 with `BASE` = 0 → ack, `rxd` = 0. `req` held high after ack → no second ack until `req` drops.
- `MP_MGMT_PERF_EN` on: PERF0 preset to 0xFFFF_FFFE, 3 cycles of `perf[0]` → reads 0x1. Off: reads 0.
- Assert `sys_rst` in ACK state → `ack` low immediately, all registers 0, first post-reset request serviced normally.
